// File: rtl/binary16_mul_iterative.sv
// binary16_mul_iterative: sequential IEEE-754 half-precision multiplier.
// Radix-2 shift-add over the 11-bit significands, one request in flight,
// fixed 12-cycle latency from acceptance to the data_valid_out pulse.
// Optional macro BINARY16_MUL_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the product is truncated and no rounding logic exists.
module binary16_mul_iterative #(
   parameter int MANT_W = 11,
   parameter int BIAS   = 15
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        data_valid_in,
   output logic [15:0] result,
   output logic        data_valid_out,
   output logic        busy
);

   localparam int ACC_W = 2 * MANT_W;
   localparam int CNT_W = $clog2(MANT_W);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_NORM = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic              accept;

   // Operand stage, captured on the acceptance edge
   logic              sign_p0;
   logic [MANT_W-1:0] ma_p0;
   logic [MANT_W-1:0] mb_p0;
   logic [4:0]        ea_p0;
   logic [4:0]        eb_p0;
   logic              qnan_p0;
   logic              inf_p0;
   logic              zero_p0;

   logic [6:0]        e_sum;
   logic signed [6:0] e_norm;
   logic signed [6:0] e_out;
   logic [MANT_W-2:0] mant_keep;
   logic [MANT_W-2:0] mant_out;
   logic [15:0]       final_res;

`ifdef BINARY16_MUL_ROUND_NEAREST_EN
   logic              guard;
   logic              sticky;
   logic [MANT_W-1:0] mant_rnd;

   // Returns {carry, mantissa}; carry means the mantissa wrapped to zero.
   function automatic logic [MANT_W-1:0] round_rne(input logic [MANT_W-2:0] m,
                                                   input logic g,
                                                   input logic st);
      round_rne = {1'b0, m} + MANT_W'(g & (st | m[0]));
   endfunction
`endif

   // Saturate to signed infinity on overflow, flush to signed zero on underflow.
   function automatic logic [15:0] sat_pack(input logic s,
                                            input logic signed [6:0] e,
                                            input logic [MANT_W-2:0] m);
      if (e >= 7'sd31)
         sat_pack = {s, 5'h1F, 10'h000};
      else if (e <= 7'sd0)
         sat_pack = {s, 15'h0000};
      else
         sat_pack = {s, e[4:0], m};
   endfunction

   assign busy   = (state != ST_IDLE);
   assign accept = (state == ST_IDLE) && data_valid_in;

   // Normalize the finished accumulator and resolve special operands.
   always_comb begin
      // 7-bit arithmetic so large sums and negative exponents stay distinguishable
      e_sum     = {2'b00, ea_p0} + {2'b00, eb_p0} + {6'd0, acc[ACC_W-1]} - 7'(BIAS);
      e_norm    = $signed(e_sum);
      mant_keep = acc[ACC_W-1] ? acc[ACC_W-2 -: MANT_W-1] : acc[ACC_W-3 -: MANT_W-1];
`ifdef BINARY16_MUL_ROUND_NEAREST_EN
      guard     = acc[ACC_W-1] ? acc[ACC_W-MANT_W-1] : acc[ACC_W-MANT_W-2];
      sticky    = acc[ACC_W-1] ? (|acc[ACC_W-MANT_W-2:0]) : (|acc[ACC_W-MANT_W-3:0]);
      mant_rnd  = round_rne(mant_keep, guard, sticky);
      mant_out  = mant_rnd[MANT_W-2:0];
      e_out     = e_norm + $signed({6'd0, mant_rnd[MANT_W-1]});
`else
      mant_out  = mant_keep;
      e_out     = e_norm;
`endif
      if (qnan_p0)
         final_res = 16'h7E00;
      else if (inf_p0)
         final_res = {sign_p0, 5'h1F, 10'h000};
      else if (zero_p0)
         final_res = {sign_p0, 15'h0000};
      else
         final_res = sat_pack(sign_p0, e_out, mant_out);
   end

   // Capture operands and special-case flags when a request is accepted.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         sign_p0 <= a[15] ^ b[15];
         ea_p0   <= a[14:10];
         eb_p0   <= b[14:10];
         ma_p0   <= {|a[14:10], a[9:0]};
         mb_p0   <= {|b[14:10], b[9:0]};
         qnan_p0 <= ((&a[14:10]) && (|a[9:0])) || ((&b[14:10]) && (|b[9:0])) ||
                    (((&a[14:10]) && !(|a[9:0])) && !(|b[14:10])) ||
                    (((&b[14:10]) && !(|b[9:0])) && !(|a[14:10]));
         inf_p0  <= (&a[14:10]) || (&b[14:10]);
         zero_p0 <= !(|a[14:10]) || !(|b[14:10]);
      end
   end

   // FSM: accept, 11 shift-add iterations, then normalize and emit the result.
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         acc            <= '0;
         result         <= 16'h0000;
         data_valid_out <= 1'b0;
      end else begin
         data_valid_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (data_valid_in) begin
                  acc   <= '0;
                  cnt   <= '0;
                  state <= ST_MUL;
               end
            end
            // Iteration stage: one multiplier bit per cycle
            ST_MUL: begin
               if (mb_p0[cnt])
                  acc <= acc + (ACC_W'(ma_p0) << cnt);
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(MANT_W - 1))
                  state <= ST_NORM;
            end
            // Output stage: register the packed result with a one-cycle strobe
            ST_NORM: begin
               result         <= final_res;
               data_valid_out <= 1'b1;
               state          <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_binary16_mul_iterative.sv
// Scoreboard bench for binary16_mul_iterative: directed vectors plus random
// operands checked against an arithmetic reference model. Honours
// BINARY16_MUL_ROUND_NEAREST_EN to select the expected rounding mode.
module tb_binary16_mul_iterative;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        dvi;
   logic [15:0] result;
   logic        dvo;
   logic        busy;

   always #5 clk_in = ~clk_in;

   binary16_mul_iterative dut (
      .clk_in        (clk_in),
      .rst           (rst),
      .a             (a),
      .b             (b),
      .data_valid_in (dvi),
      .result        (result),
      .data_valid_out(dvo),
      .busy          (busy)
   );

   typedef struct {
      logic [15:0] exp_res;
      int          due;
      logic [15:0] opa;
      logic [15:0] opb;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: exact integer product of the significands, then the
   // format's rules for exponent, rounding, overflow and specials.
   function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      int     ex, ey, fx, fy, e, sh;
      longint p, m;
      logic   s, nx, ny, ix, iy, zx, zy;
`ifdef BINARY16_MUL_ROUND_NEAREST_EN
      longint rem, half;
`endif
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      fx = int'(x[9:0]);
      fy = int'(y[9:0]);
      s  = x[15] ^ y[15];
      nx = (ex == 31) && (fx != 0);
      ny = (ey == 31) && (fy != 0);
      ix = (ex == 31) && (fx == 0);
      iy = (ey == 31) && (fy == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      if (nx || ny) return 16'h7E00;
      if ((ix || iy) && (zx || zy)) return 16'h7E00;
      if (ix || iy) return {s, 15'h7C00};
      if (zx || zy) return {s, 15'h0000};
      p = longint'(fx + 1024) * longint'(fy + 1024);
      if (p >= (longint'(1) << 21)) sh = 11;
      else sh = 10;
      e = ex + ey - 15 + (sh - 10);
      m = p >> sh;
`ifdef BINARY16_MUL_ROUND_NEAREST_EN
      rem  = p - (m << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == 2048) begin
         m = 1024;
         e = e + 1;
      end
`endif
      if (e >= 31) return {s, 15'h7C00};
      if (e <= 0) return {s, 15'h0000};
      return {s, 5'(e), 10'(m)};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] v;
      int sel;
      v   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6) v[14:10] = 5'($urandom_range(8, 22));
      else if (sel == 6) v[14:10] = 5'd31;
      else if (sel == 7) v[14:10] = 5'd0;
      else if (sel == 8) v[14:0] = 15'h7C00;
      return v;
   endfunction

   // Monitor: pops the scoreboard on the due cycle, otherwise expects silence.
   always @(negedge clk_in) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (sb.size() > 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            chk("dvo_at_due", 16'(dvo), 16'h0001);
            chk($sformatf("result %h*%h", e.opa, e.opb), result, e.exp_res);
            chk("busy_at_done", 16'(busy), 16'h0000);
         end else begin
            chk("dvo_quiet", 16'(dvo), 16'h0000);
            chk("busy_track", 16'(busy), 16'(sb.size() > 0));
         end
      end
   end

   task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] expv);
      int waitc;
      waitc = 0;
      while (busy === 1'b1 && waitc < 40) begin
         @(posedge clk_in); #1;
         waitc++;
      end
      chk("issue_idle", 16'(busy), 16'h0000);
      a   = xa;
      b   = xb;
      dvi = 1'b1;
      @(posedge clk_in); #1;
      dvi = 1'b0;
      sb.push_back('{expv, cyc + 12, xa, xb});
   endtask

   task automatic drain();
      int waitc;
      waitc = 0;
      while (sb.size() > 0 && waitc < 40) begin
         @(posedge clk_in); #1;
         waitc++;
      end
      chk("drain_empty", 16'(sb.size()), 16'h0000);
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst = 1'b0;
      dvi = 1'b0;
      a   = 16'h0000;
      b   = 16'h0000;
      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_result", result, 16'h0000);
      chk("reset_dvo", 16'(dvo), 16'h0000);
      chk("reset_busy", 16'(busy), 16'h0000);
      rst    = 1'b1;
      mon_en = 1'b1;
      @(posedge clk_in); #1;

      // Directed vectors, back to back (each new request lands in a completion cycle)
      issue(16'h3C00, 16'h3C00, 16'h3C00);
      issue(16'h4000, 16'h4200, 16'h4600);
      issue(16'h3E00, 16'h3E00, 16'h4080);
      issue(16'hC000, 16'h3800, 16'hBC00);
      issue(16'h7BFF, 16'h7BFF, 16'h7C00);
      issue(16'h0400, 16'h0400, 16'h0000);
      issue(16'h7C00, 16'h0000, 16'h7E00);
      issue(16'h0001, 16'h3C00, 16'h0000);
      issue(16'hFC00, 16'h3C00, 16'hFC00);
      issue(16'h7C01, 16'h3C00, 16'h7E00);
`ifdef BINARY16_MUL_ROUND_NEAREST_EN
      issue(16'h3E01, 16'h3E01, 16'h4082);
`else
      issue(16'h3E01, 16'h3E01, 16'h4081);
`endif
      drain();

      // A second strobe mid-operation must be ignored
      issue(16'h4000, 16'h4200, 16'h4600);
      repeat (3) @(posedge clk_in);
      #1;
      a   = 16'h3C00;
      b   = 16'h3C00;
      dvi = 1'b1;
      @(posedge clk_in); #1;
      dvi = 1'b0;
      drain();
      repeat (14) @(posedge clk_in);
      #1;

      // Reset mid-operation abandons the request
      issue(16'h3E00, 16'h3E00, 16'h4080);
      repeat (5) @(posedge clk_in);
      #1;
      mon_en = 1'b0;
      sb.delete();
      rst = 1'b0;
      @(posedge clk_in); #1;
      chk("midrst_result", result, 16'h0000);
      chk("midrst_busy", 16'(busy), 16'h0000);
      chk("midrst_dvo", 16'(dvo), 16'h0000);
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (15) @(posedge clk_in);
      #1;

      // Random operands against the reference model
      for (int i = 0; i < 150; i++) begin
         ra = rand_op();
         rb = rand_op();
         issue(ra, rb, ref_mul(ra, rb));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 14)) @(posedge clk_in);
            #1;
         end
      end
      drain();
      repeat (3) @(posedge clk_in);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
